dab_sequencer: RTL and testbench

// - Supervisory controller for the DAB power stage: sits between external commands and the controller/PWM pair.
// - Generates the period sync pulse and gates PWM enable.
// - Soft-starts and soft-stops the current reference, one step per switching period.
// - Trips to FAULT on sustained over/under-voltage of the DC links.

---
 rtl/dab_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_dab_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dab_sequencer.sv
// Supervisory sequencer for the DAB power stage: period sync, PWM gating, soft start/stop
// of the current reference and DC-link fault trips. Build option: DAB_SEQ_AUTORESTART_EN.
module dab_sequencer #(
    parameter int unsigned SYNC_DIV  = 1000,
    parameter logic [11:0] VDC_MAX   = 12'd900,
    parameter logic [11:0] VDC_MIN   = 12'd50,
    parameter int unsigned FILT_N    = 4,
    parameter logic [11:0] RAMP_STEP = 12'd2,
    parameter logic [15:0] COOLDOWN  = 16'd200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               clr_fault,
    input  logic               trigger,
    input  logic        [11:0] Vdc1,
    input  logic        [11:0] Vdc2,
    input  logic signed [11:0] Iref_tgt,
    output logic               sync,
    output logic signed [11:0] Iref_out,
    output logic               pwm_en,
    output logic        [2:0]  state,
    output logic        [1:0]  fault_code
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_SOFTSTART = 3'd2,
        S_RUN       = 3'd3,
        S_RAMPDOWN  = 3'd4,
        S_FAULT     = 3'd5
    } state_e;

    localparam int          SW        = (SYNC_DIV > 1) ? $clog2(SYNC_DIV) : 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_DIV - 1);
    localparam logic [3:0]  FILT      = 4'(FILT_N);

    state_e             state_q, state_d;
    logic [SW-1:0]      sync_cnt_q, sync_cnt_d;
    logic               sync_q, sync_d;
    logic [3:0]         ov_cnt_q, ov_cnt_d, uv_cnt_q, uv_cnt_d, ok_cnt_q, ok_cnt_d;
    logic [3:0]         ov_upd, uv_upd, ok_upd;
    logic signed [11:0] iref_q, iref_d, iref_ramp;
    logic               pwm_q, pwm_d;
    logic [1:0]         fc_q, fc_d;
    logic               ov_now, uv_now, ov_trip, uv_trip, ok_full, ramping;
    logic signed [12:0] iref_ext, ramp_goal, ramp_diff, step13, ramp_next;

`ifdef DAB_SEQ_AUTORESTART_EN
    logic [15:0] cool_q, cool_d, cool_upd;
    logic        unused_clr;
    assign unused_clr = clr_fault;
`else
    localparam logic [15:0] unused_cooldown = COOLDOWN;
`endif

    // Free-running period counter; sync marks the cycle the count sits at zero.
    always_comb begin
        sync_cnt_d = (sync_cnt_q == SYNC_LAST) ? '0 : sync_cnt_q + SW'(1);
        sync_d     = (sync_cnt_d == '0);
    end

    always_comb begin
        ov_now = (Vdc1 > VDC_MAX) || (Vdc2 > VDC_MAX);
        uv_now = (Vdc1 < VDC_MIN);
        ov_upd = ov_cnt_q;
        uv_upd = uv_cnt_q;
        ok_upd = ok_cnt_q;
        if (trigger) begin
            ov_upd = !ov_now ? 4'd0 : (ov_cnt_q == FILT) ? FILT : ov_cnt_q + 4'd1;
            uv_upd = !uv_now ? 4'd0 : (uv_cnt_q == FILT) ? FILT : uv_cnt_q + 4'd1;
            ok_upd = (ov_now || uv_now) ? 4'd0 : (ok_cnt_q == FILT) ? FILT : ok_cnt_q + 4'd1;
        end
        ov_trip = (ov_upd == FILT);
        uv_trip = (uv_upd == FILT);
        ok_full = (ok_upd == FILT);
    end

    // Rate limiter: 13-bit step toward the goal, snapping to it once within one step.
    always_comb begin
        iref_ext  = {iref_q[11], iref_q};
        ramp_goal = (state_q == S_RAMPDOWN) ? 13'sd0 : {Iref_tgt[11], Iref_tgt};
        step13    = signed'({1'b0, RAMP_STEP});
        ramp_diff = ramp_goal - iref_ext;
        if (ramp_diff > step13)
            ramp_next = iref_ext + step13;
        else if (ramp_diff < -step13)
            ramp_next = iref_ext - step13;
        else
            ramp_next = ramp_goal;
        ramping   = (state_q == S_SOFTSTART) || (state_q == S_RUN) || (state_q == S_RAMPDOWN);
        iref_ramp = (trigger && ramping) ? ramp_next[11:0] : iref_q;
    end

    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
`ifdef DAB_SEQ_AUTORESTART_EN
        cool_upd = cool_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (ov_trip) begin
                    state_d = S_FAULT;
                    fc_d    = 2'd1;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (ok_full) begin
                    state_d = S_SOFTSTART;
                end
            end
            S_SOFTSTART, S_RUN, S_RAMPDOWN: begin
                if (ov_trip) begin
                    state_d = S_FAULT;
                    fc_d    = 2'd1;
                end else if (uv_trip) begin
                    state_d = S_FAULT;
                    fc_d    = 2'd2;
                end else if (state_q == S_SOFTSTART) begin
                    if (stop)                       state_d = S_RAMPDOWN;
                    else if (iref_ramp == Iref_tgt) state_d = S_RUN;
                end else if (state_q == S_RUN) begin
                    if (stop || !start) state_d = S_RAMPDOWN;
                end else begin
                    if (iref_ramp == 12'sd0) state_d = S_IDLE;
                end
            end
            S_FAULT: begin
`ifdef DAB_SEQ_AUTORESTART_EN
                if (trigger) begin
                    cool_upd = cool_q + 16'd1;
                    if (cool_upd == COOLDOWN) begin
                        state_d = S_IDLE;
                        fc_d    = 2'd0;
                    end
                end
`else
                if (clr_fault && !start) begin
                    state_d = S_IDLE;
                    fc_d    = 2'd0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                fc_d    = 2'd0;
            end
        endcase
    end

    // FAULT drops the reference without ramping and holds the filters cleared.
    always_comb begin
        iref_d   = (state_d == S_FAULT) ? 12'sd0 : iref_ramp;
        ov_cnt_d = (state_d == S_FAULT) ? 4'd0 : ov_upd;
        uv_cnt_d = (state_d == S_FAULT) ? 4'd0 : uv_upd;
        ok_cnt_d = (state_d == S_FAULT) ? 4'd0 : ok_upd;
        pwm_d    = (state_d == S_SOFTSTART) || (state_d == S_RUN) || (state_d == S_RAMPDOWN);
`ifdef DAB_SEQ_AUTORESTART_EN
        cool_d   = (state_d == S_FAULT) ? cool_upd : 16'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync_cnt_q <= '0;
            sync_q     <= 1'b0;
            ov_cnt_q   <= '0;
            uv_cnt_q   <= '0;
            ok_cnt_q   <= '0;
            iref_q     <= '0;
            pwm_q      <= 1'b0;
            fc_q       <= '0;
`ifdef DAB_SEQ_AUTORESTART_EN
            cool_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            sync_q     <= sync_d;
            ov_cnt_q   <= ov_cnt_d;
            uv_cnt_q   <= uv_cnt_d;
            ok_cnt_q   <= ok_cnt_d;
            iref_q     <= iref_d;
            pwm_q      <= pwm_d;
            fc_q       <= fc_d;
`ifdef DAB_SEQ_AUTORESTART_EN
            cool_q     <= cool_d;
`endif
        end
    end

    assign state      = state_q;
    assign sync       = sync_q;
    assign Iref_out   = iref_q;
    assign pwm_en     = pwm_q;
    assign fault_code = fc_q;

endmodule

// File: tb/tb_dab_sequencer.sv
// Bench for dab_sequencer: per-cycle reference model, a table of scenario rows with fixed
// expectations, hand sequences for sync timing and mid-run reset, then randomized traffic.
module tb_dab_sequencer;

    localparam int P_IDLE = 0, P_CHECK = 1, P_SS = 2, P_RUN = 3, P_RD = 4, P_FAULT = 5;

    logic               clk = 1'b0;
    logic               rst, start, stop, clr_fault, trigger;
    logic        [11:0] vdc1, vdc2;
    logic signed [11:0] iref_tgt;
    logic               sync, pwm_en;
    logic signed [11:0] iref_out;
    logic        [2:0]  state;
    logic        [1:0]  fault_code;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    int m_state, m_iref, m_fc, m_ov, m_uv, m_ok, m_cnt, m_cool;
    bit m_sync, m_pwm;

    dab_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr_fault(clr_fault),
        .trigger(trigger), .Vdc1(vdc1), .Vdc2(vdc2), .Iref_tgt(iref_tgt),
        .sync(sync), .Iref_out(iref_out), .pwm_en(pwm_en), .state(state),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    function automatic int ramp(int cur, int goal);
        if (goal - cur > 2)  return cur + 2;
        if (goal - cur < -2) return cur - 2;
        return goal;
    endfunction

    function automatic int sat_inc(int v, bit cond);
        if (!cond) return 0;
        return (v < 4) ? v + 1 : 4;
    endfunction

    task automatic model_clk();
        int ov, uv, ok, nxt, iref, fc, tgt;
        bit hi, lo;
        if (rst) begin
            m_state = P_IDLE; m_iref = 0; m_fc = 0; m_ov = 0; m_uv = 0; m_ok = 0;
            m_cnt = 0; m_cool = 0; m_sync = 0; m_pwm = 0;
            return;
        end
        m_cnt  = (m_cnt + 1) % 1000;
        m_sync = (m_cnt == 0);
        hi  = (vdc1 > 900) || (vdc2 > 900);
        lo  = (vdc1 < 50);
        tgt = int'(iref_tgt);
        ov = m_ov; uv = m_uv; ok = m_ok;
        if (trigger) begin
            ov = sat_inc(m_ov, hi);
            uv = sat_inc(m_uv, lo);
            ok = sat_inc(m_ok, !hi && !lo);
        end
        iref = m_iref;
        if (trigger && m_state >= P_SS && m_state <= P_RD)
            iref = ramp(m_iref, (m_state == P_RD) ? 0 : tgt);
        nxt = m_state;
        fc  = m_fc;
        if (m_state >= P_CHECK && m_state <= P_RD && ov == 4) begin
            nxt = P_FAULT; fc = 1;
        end else if (m_state >= P_SS && m_state <= P_RD && uv == 4) begin
            nxt = P_FAULT; fc = 2;
        end else begin
            case (m_state)
                P_IDLE:  if (start && !stop) nxt = P_CHECK;
                P_CHECK: if (stop) nxt = P_IDLE; else if (ok == 4) nxt = P_SS;
                P_SS:    if (stop) nxt = P_RD; else if (iref == tgt) nxt = P_RUN;
                P_RUN:   if (stop || !start) nxt = P_RD;
                P_RD:    if (iref == 0) nxt = P_IDLE;
                default: begin
`ifdef DAB_SEQ_AUTORESTART_EN
                    if (trigger) begin
                        m_cool++;
                        if (m_cool == 200) begin nxt = P_IDLE; fc = 0; end
                    end
`else
                    if (clr_fault && !start) begin nxt = P_IDLE; fc = 0; end
`endif
                end
            endcase
        end
        if (nxt == P_FAULT) begin
            iref = 0; ov = 0; uv = 0; ok = 0;
        end else begin
            m_cool = 0;
        end
        m_state = nxt; m_iref = iref; m_fc = fc; m_ov = ov; m_uv = uv; m_ok = ok;
        m_pwm = (nxt == P_SS) || (nxt == P_RUN) || (nxt == P_RD);
    endtask

    task automatic tick();
        logic signed [11:0] e_iref;
        @(posedge clk);
        model_clk();
        cyc++;
        #1;
        e_iref = 12'(m_iref);
        checks++;
        if (state !== 3'(m_state) || iref_out !== e_iref || pwm_en !== m_pwm ||
            fault_code !== 2'(m_fc) || sync !== m_sync) begin
            errors++;
            $display("FAIL model cyc=%0d got st=%0d iref=%0d pwm=%0b fc=%0d sync=%0b exp st=%0d iref=%0d pwm=%0b fc=%0d sync=%0b",
                     cyc, state, iref_out, pwm_en, fault_code, sync,
                     m_state, m_iref, m_pwm, m_fc, m_sync);
        end
    endtask

    task automatic trig_period();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_out(string name, int e_st, int e_iref, int e_pwm, int e_fc);
        logic signed [11:0] ei;
        ei = 12'(e_iref);
        checks++;
        if (state !== 3'(e_st) || iref_out !== ei || pwm_en !== 1'(e_pwm) || fault_code !== 2'(e_fc)) begin
            errors++;
            $display("FAIL %s got st=%0d iref=%0d pwm=%0b fc=%0d exp st=%0d iref=%0d pwm=%0d fc=%0d",
                     name, state, iref_out, pwm_en, fault_code, e_st, e_iref, e_pwm, e_fc);
        end
    endtask

    typedef struct {
        bit st, sp, clr;
        int v1, v2, tgt, n;
        int e_st, e_iref, e_pwm, e_fc;
    } row_t;

    function automatic row_t mk(bit st, bit sp, bit clr, int v1, int v2, int tgt, int n,
                                int e_st, int e_iref, int e_pwm, int e_fc);
        row_t r;
        r.st = st; r.sp = sp; r.clr = clr; r.v1 = v1; r.v2 = v2; r.tgt = tgt; r.n = n;
        r.e_st = e_st; r.e_iref = e_iref; r.e_pwm = e_pwm; r.e_fc = e_fc;
        return r;
    endfunction

    function automatic logic [11:0] pick_vdc();
        int k;
        logic [11:0] tbl [10];
        tbl = '{12'd20, 12'd49, 12'd50, 12'd51, 12'd899, 12'd900, 12'd901, 12'd950, 12'd4095, 12'd500};
        k = $urandom_range(0, 15);
        return (k < 10) ? tbl[k] : 12'd500;
    endfunction

    initial begin
        row_t rows[$];
        int sync_at[$];

        rst = 1'b1; start = 0; stop = 0; clr_fault = 0; trigger = 0;
        vdc1 = 12'd500; vdc2 = 12'd400; iref_tgt = 12'sd0;
        repeat (3) tick();
        check_out("reset", P_IDLE, 0, 0, 0);
        checks++;
        if (sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_sync got %0b exp 0", sync);
        end

        // sync pulses land exactly on 1000/2000/3000 clocks after reset release
        rst = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (sync === 1'b1) sync_at.push_back(k);
        end
        checks++;
        if (sync_at.size() != 3) begin
            errors++;
            $display("FAIL sync_count got %0d exp 3", sync_at.size());
        end
        for (int i = 0; i < sync_at.size() && i < 3; i++) begin
            checks++;
            if (sync_at[i] != (i + 1) * 1000) begin
                errors++;
                $display("FAIL sync_pos%0d got %0d exp %0d", i, sync_at[i], (i + 1) * 1000);
            end
        end
        check_out("idle_after_sync", P_IDLE, 0, 0, 0);

        //                 st sp clr  v1   v2   tgt    n     st     iref pwm fc
        rows.push_back(mk(1, 0, 0, 500, 400,    10,    0, P_CHECK,    0, 0, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    10,    3, P_CHECK,    0, 0, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    10,    1, P_SS,       0, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    10,    4, P_SS,       8, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    10,    1, P_RUN,     10, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    -7,    1, P_RUN,      8, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    -7,    7, P_RUN,     -6, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    -7,    1, P_RUN,     -7, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,     6,    7, P_RUN,      6, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 950,     6,    3, P_RUN,      6, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,     6,    1, P_RUN,      6, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 950,     6,    3, P_RUN,      6, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 950,     6,    1, P_FAULT,    0, 0, 1));
        rows.push_back(mk(1, 0, 1, 500, 400,     6,    0, P_FAULT,    0, 0, 1));
        rows.push_back(mk(0, 0, 1, 500, 400,     6,    0, P_IDLE,     0, 0, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,     6,    4, P_SS,       0, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,     6,    3, P_RUN,      6, 1, 0));
        rows.push_back(mk(1, 1, 0, 500, 400,     6,    0, P_RD,       6, 1, 0));
        rows.push_back(mk(1, 1, 0, 500, 400,     6,    2, P_RD,       2, 1, 0));
        rows.push_back(mk(1, 1, 0, 500, 400,     6,    1, P_IDLE,     0, 0, 0));
        rows.push_back(mk(1, 1, 0, 500, 400,     6,    2, P_IDLE,     0, 0, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    -3,    0, P_SS,       0, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,    -3,    2, P_RUN,     -3, 1, 0));
        rows.push_back(mk(1, 0, 0,  20, 400,    -3,    4, P_FAULT,    0, 0, 2));
        rows.push_back(mk(0, 0, 1, 500, 400,    -3,    0, P_IDLE,     0, 0, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,  2047,    4, P_SS,       0, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,  2047, 1024, P_RUN,   2047, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400, -2048, 2048, P_RUN,  -2048, 1, 0));
        rows.push_back(mk(1, 0, 0,  20, 950, -2048,    4, P_FAULT,    0, 0, 1));
        rows.push_back(mk(0, 0, 1, 500, 400,   100,    0, P_IDLE,     0, 0, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,   100,    4, P_SS,       0, 1, 0));
        rows.push_back(mk(1, 0, 0, 500, 400,   100,    3, P_SS,       6, 1, 0));
        rows.push_back(mk(1, 1, 0, 500, 400,   100,    0, P_RD,       6, 1, 0));
        rows.push_back(mk(1, 1, 0, 500, 400,   100,    3, P_IDLE,     0, 0, 0));

        foreach (rows[i]) begin
            start = rows[i].st; stop = rows[i].sp; clr_fault = rows[i].clr;
            vdc1 = 12'(rows[i].v1); vdc2 = 12'(rows[i].v2); iref_tgt = 12'(rows[i].tgt);
            tick();
            clr_fault = 1'b0;
            tick();
            repeat (rows[i].n) trig_period();
            check_out($sformatf("row%0d", i), rows[i].e_st, rows[i].e_iref, rows[i].e_pwm, rows[i].e_fc);
        end

        // reset while ramping must restore reset values immediately
        start = 1'b1; stop = 1'b0; iref_tgt = 12'sd50;
        repeat (8) trig_period();
        check_out("pre_midreset", P_SS, 14, 1, 0);
        rst = 1'b1;
        tick();
        check_out("midreset", P_IDLE, 0, 0, 0);
        rst = 1'b0; start = 1'b0;
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            rst       = ($urandom_range(0, 1499) == 0);
            trigger   = ($urandom_range(0, 3) == 0);
            clr_fault = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) start = ~start;
            if ($urandom_range(0, 99) == 0)  stop  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 47) == 0) begin
                vdc1 = pick_vdc();
                vdc2 = pick_vdc();
            end
            if ($urandom_range(0, 79) == 0)
                iref_tgt = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($signed($urandom_range(0, 60)) - 30);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
